branch_resolve: RTL
===================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-002 SHALL have parameter PC_WIDTH, default 32, program-counter width.
REQ-003 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit counters; power of two, >= 2.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ex_valid  input  1  EX-stage instruction valid this cycle; low during stall or bubble.
REQ-007 branch  input  4  [3] conditional branch; [2:1] class: 00 eq, 10 signed lt, 11 unsigned lt, 01 reserved; [0] invert.
REQ-008 jalx  input  1  unconditional jump (JAL/JALR).
REQ-009 rd1, rd2  input  DATA_WIDTH  compare operands.
REQ-010 ex_pc  input  PC_WIDTH  PC of the EX instruction.
REQ-011 ex_target  input  PC_WIDTH  computed taken target.
REQ-012 ex_pred_taken  input  1  prediction carried down the pipe for this instruction.
REQ-013 if_pc  input  PC_WIDTH  fetch PC for the prediction lookup.
REQ-014 if_pred_taken  output  1  combinational prediction for if_pc.
REQ-015 taken  output  1  registered resolved direction.
REQ-016 mispredict  output  1  registered one-cycle flush pulse.
REQ-017 redirect_pc  output  PC_WIDTH  registered correct next PC, valid while mispredict=1.

Function
REQ-018 Comparison SHALL use rd1 - rd2 (rd1 + ~rd2 + 1): eq = zero result; signed lt = overflow XOR sign bit; unsigned lt = NOT carry-out.
REQ-019 Conditional direction SHALL be the class result XOR branch[0]; class 01 SHALL yield not-taken regardless of branch[0].
REQ-020 Resolved direction SHALL be jalx OR (branch[3] AND conditional direction).
REQ-021 Latency SHALL be one cycle: taken, mispredict and redirect_pc reflect the cycle-N inputs after the rising edge ending cycle N.
REQ-022 mispredict SHALL be set iff ex_valid AND (resolved != ex_pred_taken); otherwise cleared the next cycle (no sticky state).
REQ-023 redirect_pc SHALL be ex_target if resolved is taken, else ex_pc + 4 modulo 2^PC_WIDTH (wrap, no saturation).
REQ-024 When ex_valid=0, taken and mispredict SHALL register 0 and redirect_pc SHALL hold its value.
REQ-025 BHT index SHALL be pc[log2(BHT_DEPTH)+1:2], for both lookup and update.
REQ-026 if_pred_taken SHALL be bit [1] of the counter indexed by if_pc.
REQ-027 Update SHALL occur only when ex_valid AND branch[3] AND NOT jalx: increment if taken, decrement otherwise, saturating at 2'b11 and 2'b00.
REQ-028 Read and update of the same index in one cycle SHALL return the pre-update value (read-old).
REQ-029 Each counter SHALL be updated at most once per cycle; no other entry SHALL change.

Reset
REQ-030 With rst_n=0 at a rising edge, all counters SHALL become 2'b01 (weakly not-taken), and taken, mispredict and redirect_pc SHALL become 0.
REQ-031 Reset SHALL take priority over any simultaneous update or resolve, including reset mid-burst.
REQ-032 if_pred_taken SHALL read 0 for every index in the first cycle after reset.

Structure
REQ-033 The shared package branch_pkg SHALL hold the branch-class encodings (EQ, SLT, ULT, reserved) and the counter constants (SNT=00, WNT=01, WT=10, ST=11).
REQ-034 The counter table SHALL be one sub-module, branch_bht: one combinational read port and one synchronous write port.
REQ-035 The compare and resolve logic SHALL stay in branch_resolve.

Verification
REQ-036 Stimulus: beq with rd1=rd2=5, ex_pred_taken=0, ex_target=0x100, ex_pc=0x40. Required next cycle: taken=1, mispredict=1, redirect_pc=0x100.
REQ-037 Stimulus: blt with rd1=0xFFFFFFFF, rd2=1. Required: taken=1. Same operands with bltu: taken=0, redirect_pc=ex_pc+4.
REQ-038 Stimulus: after reset, 3 taken updates at ex_pc=0x40. Required: if_pred_taken at if_pc=0x40 goes 0,1,1 (counter 01->10->11->11). Then 4 not-taken updates: counter reaches 00 and if_pred_taken=0.
REQ-039 Stimulus: jalx=1 with ex_pred_taken=1. Required: mispredict=0 and the BHT entry unchanged. Stimulus: ex_pc=0xFFFFFFFC, not taken, mispredicted. Required: redirect_pc=0x0.
REQ-040 Stimulus: same-cycle lookup and update of index 16. Required: lookup returns the old value. Stimulus: rst_n=0 asserted while updates are in flight. Required: all counters 01 and outputs 0 on the next cycle.

Source files
------------

// File: rtl/branch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_pkg : branch-class encodings and 2-bit counter constants  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package branch_pkg;

  typedef enum logic [1:0] {
    CLS_EQ  = 2'b00,
    CLS_RSV = 2'b01,
    CLS_SLT = 2'b10,
    CLS_ULT = 2'b11
  } br_class_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating step of a 2-bit confidence counter.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic inc);
    logic [1:0] nxt;
    if (inc) begin
      nxt = (ctr == ST) ? ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_bht.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_bht : table of 2-bit counters, async read / sync write    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module branch_bht
  import branch_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] rd_pc,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [PC_WIDTH-1:0] wr_pc,
  input  logic                wr_taken
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [1:0]       ctr_q [BHT_DEPTH];
  logic [1:0]       ctr_d [BHT_DEPTH];
  logic             w_unused_pc_bits;

  assign w_rd_idx = rd_pc[IDX_W+1:2];
  assign w_wr_idx = wr_pc[IDX_W+1:2];

  // Only the index field of either PC selects an entry.
  assign w_unused_pc_bits = ^{rd_pc, wr_pc};

  // Read comes straight off the flops, so a same-cycle update is never seen.
  assign rd_ctr = ctr_q[w_rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[w_wr_idx] = ctr_next(ctr_q[w_wr_idx], wr_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr_q[i] <= WNT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_resolve : EX-stage branch compare, mispredict and BHT     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module branch_resolve
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int BHT_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [3:0]            branch,
  input  logic                  jalx,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] rd2,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic [PC_WIDTH-1:0]   ex_target,
  input  logic                  ex_pred_taken,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  if_pred_taken,
  output logic                  taken,
  output logic                  mispredict,
  output logic [PC_WIDTH-1:0]   redirect_pc
);

  localparam logic [PC_WIDTH-1:0] C_PC_STEP = PC_WIDTH'(4);

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_carry;
  logic                  w_ovf;
  logic                  w_eq;
  logic                  w_slt;
  logic                  w_ult;
  logic                  w_cond;
  logic                  w_resolved;
  logic                  w_bht_we;
  logic [1:0]            w_if_ctr;

  logic                  taken_q, taken_d;
  logic                  mispredict_q, mispredict_d;
  logic [PC_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;

  // rd1 - rd2 as rd1 + ~rd2 + 1, keeping the carry-out for the unsigned test.
  assign w_sum   = {1'b0, rd1} + {1'b0, ~rd2} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign w_diff  = w_sum[DATA_WIDTH-1:0];
  assign w_carry = w_sum[DATA_WIDTH];
  assign w_ovf   = (rd1[DATA_WIDTH-1] != rd2[DATA_WIDTH-1]) &&
                   (w_diff[DATA_WIDTH-1] != rd1[DATA_WIDTH-1]);
  assign w_eq    = (w_diff == '0);
  assign w_slt   = w_ovf ^ w_diff[DATA_WIDTH-1];
  assign w_ult   = ~w_carry;

  always_comb begin
    w_cond = 1'b0;
    case (br_class_e'(branch[2:1]))
      CLS_EQ:  w_cond = w_eq  ^ branch[0];
      CLS_SLT: w_cond = w_slt ^ branch[0];
      CLS_ULT: w_cond = w_ult ^ branch[0];
      default: w_cond = 1'b0;
    endcase
  end

  assign w_resolved = jalx | (branch[3] & w_cond);
  assign w_bht_we   = ex_valid & branch[3] & ~jalx;

  always_comb begin
    taken_d       = 1'b0;
    mispredict_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (ex_valid) begin
      taken_d       = w_resolved;
      mispredict_d  = (w_resolved != ex_pred_taken);
      redirect_pc_d = w_resolved ? ex_target : (ex_pc + C_PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      taken_q       <= taken_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  branch_bht #(
    .PC_WIDTH  (PC_WIDTH),
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_pc    (if_pc),
    .rd_ctr   (w_if_ctr),
    .wr_en    (w_bht_we),
    .wr_pc    (ex_pc),
    .wr_taken (w_resolved)
  );

  assign if_pred_taken = w_if_ctr[1];
  assign taken         = taken_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;

endmodule
`default_nettype wire
